elixirchip_es1_spu_sub_seq: RTL and testbench
=============================================

ELIXIRCHIP_ES1_SPU_SUB_SEQ -- requirements
Module: elixirchip_es1_spu_sub_seq

Interface
REQ-001 SHALL have parameter WORDS, default 4, number of operand words (legal: >=2).
REQ-002 SHALL have parameter DATA_BITS, default 8, word width in bits (legal: >=2).
REQ-003 SHALL have parameter LATENCY, default 1, internal word-subtractor pipeline depth (legal: >=0).
REQ-004 SHALL have parameters DEVICE "RTL", SIMULATION "false", DEBUG "false", passed unchanged to the internal subtractor.
REQ-005 SHALL have port: reset  in  1  asynchronous reset, active-high.
REQ-006 SHALL have port: clk  in  1  clock; the only clock in the block.
REQ-007 SHALL have port: cke  in  1  clock enable; 0 freezes all state.
REQ-008 SHALL have port: s_data0  in  WORDS*DATA_BITS  minuend.
REQ-009 SHALL have port: s_data1  in  WORDS*DATA_BITS  subtrahend.
REQ-010 SHALL have port: s_valid  in  1  request valid.
REQ-011 SHALL have port: s_ready  out  1  request accepted when s_valid & s_ready on a cke=1 edge.
REQ-012 SHALL have port: m_data  out  WORDS*DATA_BITS  difference, modulo 2^(WORDS*DATA_BITS).
REQ-013 SHALL have port: m_borrow  out  1  1 when s_data0 < s_data1 unsigned.
REQ-014 SHALL have port: m_overflow  out  1  1 on two's-complement signed overflow.
REQ-015 SHALL have port: m_valid  out  1  result valid.
REQ-016 SHALL have port: m_ready  in  1  result consumed when m_valid & m_ready on a cke=1 edge.
REQ-017 SHALL have port: busy  out  1  1 in any state other than IDLE.

Function
REQ-018 SHALL implement FSM IDLE, ISSUE, WAIT, DONE; all transitions only on clk edges with cke=1.
REQ-019 IDLE: s_ready=1; on accept, capture both operands, word index=0, carry register=1, go ISSUE.
REQ-020 ISSUE: drive one word-subtract (data0 word[idx] + ~data1 word[idx] + carry) with valid=1 for exactly one cycle; go WAIT with wait counter=LATENCY, or capture immediately when LATENCY=0.
REQ-021 WAIT: decrement counter each enabled cycle; result word captured into m_data word[idx] and carry register updated from subtractor carry exactly LATENCY enabled cycles after issue.
REQ-022 After capture: if idx==WORDS-1 go DONE, else idx+1 and go ISSUE; words processed LSB first, one word in flight at most.
REQ-023 Latency: m_valid SHALL first be high exactly WORDS*(LATENCY+1) enabled edges after the accept edge.
REQ-024 DONE: m_valid=1; m_data, m_borrow, m_overflow held stable until m_valid & m_ready, then go IDLE (s_ready=1 the following cycle; no overlap of request and result).
REQ-025 m_borrow SHALL equal NOT final carry; m_overflow SHALL equal final carry XOR carry into the top bit of the last word.
REQ-026 s_ready SHALL be 0 in ISSUE, WAIT, DONE; s_valid there is ignored and not captured.
REQ-027 cke=0 SHALL freeze FSM, index, counter, carry, outputs, and the internal subtractor pipeline; no handshake completes.
REQ-028 m_data SHALL not be observed by the bench while m_valid=0; partially written words are permitted internally.

Reset
REQ-029 reset=1 SHALL asynchronously force IDLE, index=0, counter=0, carry=1, m_data=0, m_borrow=0, m_overflow=0, m_valid=0, busy=0.
REQ-030 s_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-031 Reset mid-operation (ISSUE/WAIT/DONE) SHALL abort the operation; no result is presented and the next accepted request computes correctly.

Verification (WORDS=4, DATA_BITS=8, LATENCY=1 unless stated)
REQ-032 0x00000100 - 0x00000001 -> m_data=0x000000FF, m_borrow=0, m_overflow=0, m_valid rises 8 edges after accept.
REQ-033 0x00000000 - 0x00000001 -> m_data=0xFFFFFFFF, m_borrow=1, m_overflow=0.
REQ-034 0x80000000 - 0x00000001 -> m_data=0x7FFFFFFF, m_borrow=0, m_overflow=1.
REQ-035 m_ready=0 for 5 cycles in DONE -> m_valid and outputs constant, s_ready=0; m_ready=1 -> IDLE, s_ready=1 next cycle.
REQ-036 cke=0 for 3 cycles during WAIT -> m_valid delayed exactly 3 cycles, result unchanged; LATENCY=0 build: m_valid 4 edges after accept.
REQ-037 reset pulsed during word 2 -> all outputs 0 immediately, s_ready=1 after release; following 0x12345678 - 0x02345679 -> 0x0FFFFFFF, m_borrow=0.

Source files
------------

// File: rtl/elixirchip_es1_spu_sub_seq.sv
// Multi-word unsigned/signed subtractor: walks the operands LSB word first through one
// pipelined word subtractor, one word in flight, then holds the result until consumed.

module elixirchip_es1_spu_sub_seq_word #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned LATENCY    = 1,
    parameter string       DEVICE     = "RTL",
    parameter string       SIMULATION = "false",
    parameter string       DEBUG      = "false"
) (
    input  logic                 reset,
    input  logic                 clk,
    input  logic                 cke,
    input  logic [DATA_BITS-1:0] a,
    input  logic [DATA_BITS-1:0] b,
    input  logic                 carry_in,
    output logic [DATA_BITS-1:0] y,
    output logic                 carry_out,
    output logic                 carry_top
);
    localparam int unsigned PW = DATA_BITS + 2;
    // Data-path stages only take a reset in generic RTL, simulation or debug builds.
    localparam bit ResetData = (DEVICE == "RTL") || (SIMULATION == "true") || (DEBUG == "true");

    logic [DATA_BITS:0] sum_c;
    logic [PW-1:0]      res_c;
    logic [PW-1:0]      out_c;

    // Carry into the top bit recovered from sum bit = a ^ ~b ^ carry.
    always_comb begin
        sum_c = {1'b0, a} + {1'b0, ~b} + {{DATA_BITS{1'b0}}, carry_in};
        res_c = {sum_c, sum_c[DATA_BITS-1] ^ a[DATA_BITS-1] ^ ~b[DATA_BITS-1]};
    end

    generate
        if (LATENCY == 0) begin : g_comb
            assign out_c = res_c;
        end else begin : g_pipe
            for (genvar s = 0; s < LATENCY; s++) begin : g_stage
                logic [PW-1:0] stage_d;
                logic [PW-1:0] stage_q;
                if (s == 0) begin : g_first
                    always_comb stage_d = res_c;
                end else begin : g_next
                    always_comb stage_d = g_stage[s-1].stage_q;
                end
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        if (ResetData) stage_q <= '0;
                    end else if (cke) begin
                        stage_q <= stage_d;
                    end
                end
            end
            assign out_c = g_stage[LATENCY-1].stage_q;
        end
    endgenerate

    assign {carry_out, y, carry_top} = out_c;
endmodule

module elixirchip_es1_spu_sub_seq #(
    parameter int unsigned WORDS      = 4,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned LATENCY    = 1,
    parameter string       DEVICE     = "RTL",
    parameter string       SIMULATION = "false",
    parameter string       DEBUG      = "false"
) (
    input  logic                         reset,
    input  logic                         clk,
    input  logic                         cke,
    input  logic [WORDS*DATA_BITS-1:0]   s_data0,
    input  logic [WORDS*DATA_BITS-1:0]   s_data1,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [WORDS*DATA_BITS-1:0]   m_data,
    output logic                         m_borrow,
    output logic                         m_overflow,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         busy
);
    localparam int unsigned NBits = WORDS * DATA_BITS;
    localparam int unsigned IdxW  = $clog2(WORDS);
    localparam int unsigned CntW  = (LATENCY == 0) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                carry_q, carry_d;
    logic [NBits-1:0]    a_q, a_d, b_q, b_d;
    logic [NBits-1:0]    data_q, data_d;
    logic                borrow_q, borrow_d;
    logic                overflow_q, overflow_d;
    logic                valid_q, valid_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;

    int unsigned          lsb_c;
    logic                 capture_c;
    logic [DATA_BITS-1:0] sub_a_c, sub_b_c, sub_y;
    logic                 sub_carry, sub_top;

    elixirchip_es1_spu_sub_seq_word #(
        .DATA_BITS  (DATA_BITS),
        .LATENCY    (LATENCY),
        .DEVICE     (DEVICE),
        .SIMULATION (SIMULATION),
        .DEBUG      (DEBUG)
    ) u_word (
        .reset     (reset),
        .clk       (clk),
        .cke       (cke),
        .a         (sub_a_c),
        .b         (sub_b_c),
        .carry_in  (carry_q),
        .y         (sub_y),
        .carry_out (sub_carry),
        .carry_top (sub_top)
    );

    // Next-state: sequencing, word capture and result flags.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        a_d        = a_q;
        b_d        = b_q;
        data_d     = data_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;
        capture_c  = 1'b0;
        lsb_c      = 32'(idx_q) * DATA_BITS;
        sub_a_c    = a_q[lsb_c +: DATA_BITS];
        sub_b_c    = b_q[lsb_c +: DATA_BITS];

        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    a_d     = s_data0;
                    b_d     = s_data1;
                    idx_d   = '0;
                    carry_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (LATENCY == 0) begin
                    capture_c = 1'b1;
                end else begin
                    cnt_d   = CntW'(LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CntW'(1)) capture_c = 1'b1;
                else                   cnt_d     = cnt_q - CntW'(1);
            end
            DONE: begin
                if (m_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (capture_c) begin
            data_d[lsb_c +: DATA_BITS] = sub_y;
            carry_d = sub_carry;
            cnt_d   = '0;
            if (idx_q == IdxW'(WORDS - 1)) begin
                borrow_d   = ~sub_carry;
                overflow_d = sub_carry ^ sub_top;
                state_d    = DONE;
            end else begin
                idx_d   = idx_q + IdxW'(1);
                state_d = ISSUE;
            end
        end

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            data_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else if (cke) begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            a_q        <= a_d;
            b_q        <= b_d;
            data_q     <= data_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign s_ready    = ready_q;
    assign busy       = busy_q;
    assign m_valid    = valid_q;
    assign m_data     = data_q;
    assign m_borrow   = borrow_q;
    assign m_overflow = overflow_q;
endmodule

// File: tb/tb_elixirchip_es1_spu_sub_seq.sv
// Bench for elixirchip_es1_spu_sub_seq: transaction-level reference model plus directed cases
// (LATENCY=1 main instance, LATENCY=0 second instance).
`timescale 1ns/1ps
module tb_elixirchip_es1_spu_sub_seq;
    localparam int unsigned WORDS     = 4;
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned LATENCY   = 1;
    localparam int unsigned N         = WORDS * DATA_BITS;
    localparam int          LAT_EDGES = WORDS * (LATENCY + 1);

    logic         clk = 1'b0, reset = 1'b1, cke = 1'b1;
    logic [N-1:0] s_data0 = '0, s_data1 = '0, m_data;
    logic         s_valid = 1'b0, s_ready, m_borrow, m_overflow, m_valid, m_ready = 1'b0, busy;
    logic [N-1:0] z_data0 = '0, z_data1 = '0, z_m_data;
    logic         z_valid = 1'b0, z_ready, z_borrow, z_overflow, z_m_valid, z_m_ready = 1'b0, z_busy;

    int checks = 0, failures = 0, txn_done = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    elixirchip_es1_spu_sub_seq #(.WORDS(WORDS), .DATA_BITS(DATA_BITS), .LATENCY(LATENCY)) dut (
        .reset(reset), .clk(clk), .cke(cke), .s_data0(s_data0), .s_data1(s_data1),
        .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data), .m_borrow(m_borrow),
        .m_overflow(m_overflow), .m_valid(m_valid), .m_ready(m_ready), .busy(busy));

    elixirchip_es1_spu_sub_seq #(.WORDS(WORDS), .DATA_BITS(DATA_BITS), .LATENCY(0)) dut_l0 (
        .reset(reset), .clk(clk), .cke(cke), .s_data0(z_data0), .s_data1(z_data1),
        .s_valid(z_valid), .s_ready(z_ready), .m_data(z_m_data), .m_borrow(z_borrow),
        .m_overflow(z_overflow), .m_valid(z_m_valid), .m_ready(z_m_ready), .busy(z_busy));

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h required=0x%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: full-width arithmetic, flags from the operand/result sign bits.
    function automatic logic [N+1:0] ref_sub(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] d;
        logic bo, ov;
        d  = a - b;
        bo = (a < b);
        ov = (a[N-1] != b[N-1]) && (d[N-1] != a[N-1]);
        return {bo, ov, d};
    endfunction

    // Transaction model: idle -> busy for LAT_EDGES enabled edges -> done until consumed.
    typedef enum int {M_IDLE, M_BUSY, M_DONE} mst_t;
    mst_t         mst = M_IDLE;
    int           mcnt = 0;
    logic [N-1:0] mdiff = '0;
    logic         mborrow = 1'b0, movf = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mst  <= M_IDLE;
            mcnt <= 0;
        end else if (cke) begin
            case (mst)
                M_IDLE: if (s_valid) begin
                    {mborrow, movf, mdiff} <= ref_sub(s_data0, s_data1);
                    mcnt <= LAT_EDGES;
                    mst  <= M_BUSY;
                end
                M_BUSY: begin
                    mcnt <= mcnt - 1;
                    if (mcnt == 1) mst <= M_DONE;
                end
                M_DONE: if (m_ready) begin
                    mst      <= M_IDLE;
                    txn_done <= txn_done + 1;
                end
                default: mst <= M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk1("model_s_ready", s_ready, mst == M_IDLE);
            chk1("model_busy", busy, mst != M_IDLE);
            chk1("model_m_valid", m_valid, mst == M_DONE);
            if (mst == M_DONE) begin
                chkw("model_m_data", m_data, mdiff);
                chk1("model_m_borrow", m_borrow, mborrow);
                chk1("model_m_overflow", m_overflow, movf);
            end
        end
    end

    task automatic run_txn(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] exp_d, input logic exp_bo, input logic exp_ov,
                           input int exp_edges, input int hold, input int pause_at, input int pause_len);
        int k;
        int w;
        w = 0;
        while (!s_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk1({name, "_idle_wait"}, s_ready, 1'b1);
        s_data0 = a;
        s_data1 = b;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        s_data0 = $urandom;
        s_data1 = $urandom;
        k = 0;
        while (!m_valid && k < 200) begin
            if (k == pause_at) cke = 1'b0;
            if (k == pause_at + pause_len) cke = 1'b1;
            @(negedge clk);
            k++;
        end
        cke = 1'b1;
        chki({name, "_latency"}, k, exp_edges);
        chkw({name, "_m_data"}, m_data, exp_d);
        chk1({name, "_m_borrow"}, m_borrow, exp_bo);
        chk1({name, "_m_overflow"}, m_overflow, exp_ov);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk1({name, "_hold_valid"}, m_valid, 1'b1);
            chkw({name, "_hold_data"}, m_data, exp_d);
            chk1({name, "_hold_s_ready"}, s_ready, 1'b0);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk1({name, "_release_s_ready"}, s_ready, 1'b1);
        chk1({name, "_release_m_valid"}, m_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int k;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk1("reset_m_valid", m_valid, 1'b0);
        chk1("reset_busy", busy, 1'b0);
        chkw("reset_m_data", m_data, '0);
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk1("post_reset_s_ready", s_ready, 1'b1);

        run_txn("sub_0100_1", 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0, LAT_EDGES, 0, -1, 0);
        run_txn("sub_0_1", 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, LAT_EDGES, 5, -1, 0);
        run_txn("sub_8000_1", 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, LAT_EDGES, 0, -1, 0);
        run_txn("cke_pause", 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0, LAT_EDGES + 3, 2, 3, 3);

        // Abort while word 2 is in flight.
        s_data0 = 32'h1111_1111;
        s_data1 = 32'h0101_0101;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk1("abort_busy_before", busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk1("abort_m_valid", m_valid, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chkw("abort_m_data", m_data, '0);
        chk1("abort_m_borrow", m_borrow, 1'b0);
        chk1("abort_m_overflow", m_overflow, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk1("abort_s_ready", s_ready, 1'b1);
        run_txn("after_abort", 32'h1234_5678, 32'h0234_5679, 32'h0FFF_FFFF, 1'b0, 1'b0, LAT_EDGES, 0, -1, 0);

        // Random traffic: s_valid/data churn every cycle, cke and m_ready random.
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            cke     = ($urandom_range(0, 4) != 0);
            m_ready = 1'($urandom_range(0, 1));
            s_valid = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: begin s_data0 = $urandom;                   s_data1 = $urandom; end
                1: begin s_data0 = 32'($urandom_range(0, 3));  s_data1 = 32'($urandom_range(0, 3)); end
                2: begin s_data0 = {1'b1, 31'($urandom)};       s_data1 = {1'b0, 31'($urandom)}; end
                default: begin s_data0 = $urandom;             s_data1 = s_data0; end
            endcase
        end
        cke = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        k = 0;
        while (mst != M_IDLE && k < 100) begin
            @(negedge clk);
            k++;
        end
        m_ready = 1'b0;
        chk1("drain_idle", s_ready, 1'b1);
        checks++;
        if (txn_done < 20) begin
            failures++;
            $display("FAIL random_txn_count actual=%0d required>=20", txn_done);
        end

        // LATENCY=0 instance.
        @(negedge clk);
        z_data0 = 32'h8000_0000;
        z_data1 = 32'h0000_0001;
        z_valid = 1'b1;
        chk1("l0_s_ready", z_ready, 1'b1);
        @(negedge clk);
        z_valid = 1'b0;
        k = 0;
        while (!z_m_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chki("l0_latency", k, WORDS);
        chkw("l0_m_data", z_m_data, 32'h7FFF_FFFF);
        chk1("l0_m_borrow", z_borrow, 1'b0);
        chk1("l0_m_overflow", z_overflow, 1'b1);
        chk1("l0_busy", z_busy, 1'b1);
        z_m_ready = 1'b1;
        @(negedge clk);
        z_m_ready = 1'b0;
        chk1("l0_release_s_ready", z_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
